// File: rtl/wc_tile_loader_pkg.sv
// Shared constants, FSM encoding and index helper for the Winograd F(2x2,3x3) tile loader.
package wc_tile_loader_pkg;

  localparam int DW = 10;
  localparam int K  = 3;
  localparam int T  = 4;
  localparam int NW = K * K;
  localparam int NX = T * T;
  localparam int CW = $clog2(NX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_LOAD_X = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [CW-1:0] W_LAST = CW'(NW - 1);
  localparam logic [CW-1:0] X_LAST = CW'(NX - 1);

  function automatic logic [CW-1:0] idx_inc(input logic [CW-1:0] idx);
    return idx + CW'(1);
  endfunction

endpackage

// File: rtl/wc_tile_loader_if.sv
// Stream-in and tile-out bundle between the pad stream, the loader and the Winograd core.
interface wc_tile_loader_if;
  import wc_tile_loader_pkg::*;

  // A word moves when d_valid & in_ready at a clock edge; a tile moves when
  // tile_valid & tile_ready. The sender holds its payload until that edge.
  logic [DW-1:0]    d_in;
  logic             d_valid;
  logic             frame_start;
  logic             in_ready;
  logic [NW*DW-1:0] w_flat;
  logic [NX*DW-1:0] x_flat;
  logic             tile_valid;
  logic             tile_ready;
  logic             w_loaded;

  modport master (
    output d_in, d_valid, frame_start, tile_ready,
    input  in_ready, w_flat, x_flat, tile_valid, w_loaded
  );

  modport slave (
    input  d_in, d_valid, frame_start, tile_ready,
    output in_ready, w_flat, x_flat, tile_valid, w_loaded
  );

endinterface

// File: rtl/wc_tile_loader_shift_bank.sv
// Indexed write-enable register array exposed as one flat bus, entry i at [i*DW +: DW].
module wc_tile_loader_shift_bank #(
  parameter int DEPTH = 9,
  parameter int DW    = 10,
  parameter int IW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic [IW-1:0]       i_idx,
  input  logic [DW-1:0]       i_data,
  output logic [DEPTH*DW-1:0] o_flat
);

  logic [DEPTH*DW-1:0] r_flat;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_flat[g*DW +: DW] <= '0;
      end else if (i_we && (i_idx == IW'(g))) begin
        r_flat[g*DW +: DW] <= i_data;
      end
    end
  end

  assign o_flat = r_flat;

endmodule

// File: rtl/wc_tile_loader.sv
// Loads one 3x3 filter then repeated 4x4 tiles from the pad stream and presents them
// in parallel to the Winograd core; weights persist until the next frame_start.
module wc_tile_loader
  import wc_tile_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  wc_tile_loader_if.slave   bus,
  output state_t            o_state
);

  state_t          r_state, w_next;
  logic [CW-1:0]   r_widx, r_xidx, w_widx_n, w_xidx_n, w_w_idx;
  logic            r_tile_valid, r_w_loaded, w_tv_n, w_wl_n;
  logic            w_in_ready, w_accept, w_w_we, w_x_we;

  // Ready comes straight from the registered state so it never depends on d_valid.
  assign w_in_ready = (r_state != ST_HOLD);
  assign w_accept   = bus.d_valid & w_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_widx       <= '0;
      r_xidx       <= '0;
      r_tile_valid <= 1'b0;
      r_w_loaded   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_widx       <= w_widx_n;
      r_xidx       <= w_xidx_n;
      r_tile_valid <= w_tv_n;
      r_w_loaded   <= w_wl_n;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_widx_n = r_widx;
    w_xidx_n = r_xidx;
    w_tv_n   = r_tile_valid;
    w_wl_n   = r_w_loaded;
    w_w_we   = 1'b0;
    w_w_idx  = r_widx;
    w_x_we   = 1'b0;
    if (w_accept && bus.frame_start) begin
      // A new frame always restarts the filter, whatever was partially loaded.
      w_w_we   = 1'b1;
      w_w_idx  = '0;
      w_widx_n = CW'(1);
      w_wl_n   = 1'b0;
      w_next   = ST_LOAD_W;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_next = ST_IDLE;
        end
        ST_LOAD_W: begin
          if (w_accept) begin
            w_w_we = 1'b1;
            if (r_widx == W_LAST) begin
              w_widx_n = '0;
              w_xidx_n = '0;
              w_wl_n   = 1'b1;
              w_next   = ST_LOAD_X;
            end else begin
              w_widx_n = idx_inc(r_widx);
            end
          end
        end
        ST_LOAD_X: begin
          if (w_accept) begin
            w_x_we = 1'b1;
            if (r_xidx == X_LAST) begin
              w_tv_n = 1'b1;
              w_next = ST_HOLD;
            end else begin
              w_xidx_n = idx_inc(r_xidx);
            end
          end
        end
        ST_HOLD: begin
          if (r_tile_valid && bus.tile_ready) begin
            w_tv_n   = 1'b0;
            w_xidx_n = '0;
            w_next   = ST_LOAD_X;
          end
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
  end

  wc_tile_loader_shift_bank #(.DEPTH(NW), .DW(DW), .IW(CW)) u_w_bank (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_w_we),
    .i_idx  (w_w_idx),
    .i_data (bus.d_in),
    .o_flat (bus.w_flat)
  );

  wc_tile_loader_shift_bank #(.DEPTH(NX), .DW(DW), .IW(CW)) u_x_bank (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_x_we),
    .i_idx  (r_xidx),
    .i_data (bus.d_in),
    .o_flat (bus.x_flat)
  );

  assign bus.in_ready   = w_in_ready;
  assign bus.tile_valid = r_tile_valid;
  assign bus.w_loaded   = r_w_loaded;
  assign o_state        = r_state;

endmodule

// File: tb/tb_wc_tile_loader.sv
// Directed bench for wc_tile_loader: filter/tile load, hold/handshake, gaps, abort, idle drop, async reset.
module tb_wc_tile_loader;
  import wc_tile_loader_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t state;
  int     total = 0;
  int     bad   = 0;

  logic [NW*DW-1:0] w_exp;
  logic [NX*DW-1:0] x_exp;

  wc_tile_loader_if bus();

  wc_tile_loader dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (state)
  );

  always #5 clk = ~clk;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input state_t obs, input state_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [NW*DW-1:0] obs, input logic [NW*DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_x(input string tag, input logic [NX*DW-1:0] obs, input logic [NX*DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic fs);
    bus.d_valid     = 1'b1;
    bus.d_in        = d;
    bus.frame_start = fs;
    step();
  endtask

  task automatic idle();
    bus.d_valid     = 1'b0;
    bus.frame_start = 1'b0;
    bus.d_in        = '0;
  endtask

  task automatic handshake();
    bus.tile_ready = 1'b1;
    step();
    bus.tile_ready = 1'b0;
  endtask

  task automatic load_filter_1to9();
    send(DW'(1), 1'b1);
    for (int i = 2; i <= 9; i++) send(DW'(i), 1'b0);
  endtask

  initial begin
    int k;
    int cyc;

    rst             = 1'b1;
    bus.d_valid     = 1'b0;
    bus.frame_start = 1'b0;
    bus.d_in        = '0;
    bus.tile_ready  = 1'b0;
    repeat (2) step();

    // reset state
    chk_b("rst_tile_valid", bus.tile_valid, 1'b0);
    chk_b("rst_in_ready", bus.in_ready, 1'b1);
    chk_b("rst_w_loaded", bus.w_loaded, 1'b0);
    chk_w("rst_w_flat", bus.w_flat, '0);
    chk_x("rst_x_flat", bus.x_flat, '0);
    chk_s("rst_state", state, ST_IDLE);
    rst = 1'b0;
    step();

    // test 1: filter 1..9 then pixels 16..31 back-to-back
    for (int i = 0; i < NW; i++) w_exp[i*DW +: DW] = DW'(i + 1);
    for (int i = 0; i < NX; i++) x_exp[i*DW +: DW] = DW'(16 + i);
    load_filter_1to9();
    chk_b("t1_w_loaded", bus.w_loaded, 1'b1);
    chk_s("t1_state_load_x", state, ST_LOAD_X);
    for (int i = 0; i < NX - 1; i++) send(DW'(16 + i), 1'b0);
    chk_b("t1_not_early", bus.tile_valid, 1'b0);
    send(DW'(31), 1'b0);
    idle();
    chk_b("t1_tile_valid", bus.tile_valid, 1'b1);
    chk_b("t1_in_ready_low", bus.in_ready, 1'b0);
    chk_s("t1_state_hold", state, ST_HOLD);
    chk_w("t1_w_flat", bus.w_flat, w_exp);
    chk_x("t1_x_flat", bus.x_flat, x_exp);

    // test 2: stall 5 cycles with a frame_start word offered, then consume
    bus.d_valid     = 1'b1;
    bus.d_in        = DW'(500);
    bus.frame_start = 1'b1;
    repeat (5) step();
    idle();
    chk_b("t2_hold_valid", bus.tile_valid, 1'b1);
    chk_x("t2_hold_x", bus.x_flat, x_exp);
    chk_w("t2_hold_w", bus.w_flat, w_exp);
    chk_b("t2_hold_w_loaded", bus.w_loaded, 1'b1);
    handshake();
    chk_b("t2_valid_fall", bus.tile_valid, 1'b0);
    chk_b("t2_in_ready", bus.in_ready, 1'b1);
    chk_s("t2_state_load_x", state, ST_LOAD_X);
    for (int i = 0; i < NX; i++) send(DW'(200 + i), 1'b0);
    idle();
    chk_b("t2_tile2_valid", bus.tile_valid, 1'b1);
    chk_x("t2_tile2_x", bus.x_flat, {DW'(215), DW'(214), DW'(213), DW'(212),
                                     DW'(211), DW'(210), DW'(209), DW'(208),
                                     DW'(207), DW'(206), DW'(205), DW'(204),
                                     DW'(203), DW'(202), DW'(201), DW'(200)});
    chk_w("t2_tile2_w", bus.w_flat, w_exp);
    chk_d("t2_w8", bus.w_flat[8*DW +: DW], DW'(9));
    handshake();
    chk_b("t2_valid_fall2", bus.tile_valid, 1'b0);

    // test 3: random gaps; idle cycles carry junk data and frame_start
    k   = 0;
    cyc = 0;
    while (k < NX && cyc < 400) begin
      if ($urandom_range(0, 1) == 1) begin
        chk_b("t3_not_early", bus.tile_valid, 1'b0);
        send(DW'(16 + k), 1'b0);
        k++;
      end else begin
        bus.d_valid     = 1'b0;
        bus.d_in        = DW'(1023);
        bus.frame_start = 1'b1;
        step();
      end
      cyc++;
    end
    idle();
    chk_i("t3_accept_count", k, NX);
    chk_b("t3_tile_valid", bus.tile_valid, 1'b1);
    chk_x("t3_x_flat", bus.x_flat, x_exp);
    chk_w("t3_w_flat", bus.w_flat, w_exp);
    chk_b("t3_w_loaded", bus.w_loaded, 1'b1);
    handshake();

    // test 4: frame_start at pixel index 7 aborts the tile
    for (int i = 0; i < 7; i++) send(DW'(16 + i), 1'b0);
    send(DW'(100), 1'b1);
    idle();
    chk_b("t4_w_loaded_clr", bus.w_loaded, 1'b0);
    chk_s("t4_state_load_w", state, ST_LOAD_W);
    chk_d("t4_w0", bus.w_flat[0 +: DW], DW'(100));
    chk_b("t4_no_tile", bus.tile_valid, 1'b0);
    for (int i = 1; i < NW; i++) send(DW'(100 + i), 1'b0);
    idle();
    for (int i = 0; i < NW; i++) w_exp[i*DW +: DW] = DW'(100 + i);
    chk_w("t4_w_flat", bus.w_flat, w_exp);
    chk_b("t4_w_loaded", bus.w_loaded, 1'b1);
    chk_s("t4_state_load_x", state, ST_LOAD_X);
    for (int i = 0; i < NX - 1; i++) send(DW'(300 + i), 1'b0);
    chk_b("t4_not_early", bus.tile_valid, 1'b0);
    send(DW'(315), 1'b0);
    idle();
    for (int i = 0; i < NX; i++) x_exp[i*DW +: DW] = DW'(300 + i);
    chk_b("t4_tile_valid", bus.tile_valid, 1'b1);
    chk_x("t4_x_flat", bus.x_flat, x_exp);
    handshake();

    // test 5: words without frame_start in IDLE are dropped
    rst = 1'b1;
    step();
    rst = 1'b0;
    send(DW'(40), 1'b0);
    send(DW'(41), 1'b0);
    send(DW'(42), 1'b0);
    idle();
    step();
    chk_b("t5_w_loaded", bus.w_loaded, 1'b0);
    chk_b("t5_tile_valid", bus.tile_valid, 1'b0);
    chk_s("t5_state_idle", state, ST_IDLE);
    chk_w("t5_w_flat", bus.w_flat, '0);

    // test 6: async reset pulse between edges while in HOLD
    load_filter_1to9();
    for (int i = 0; i < NX; i++) send(DW'(16 + i), 1'b0);
    idle();
    chk_b("t6_pre_valid", bus.tile_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_b("t6_tile_valid", bus.tile_valid, 1'b0);
    chk_w("t6_w_flat", bus.w_flat, '0);
    chk_x("t6_x_flat", bus.x_flat, '0);
    chk_b("t6_in_ready", bus.in_ready, 1'b1);
    chk_b("t6_w_loaded", bus.w_loaded, 1'b0);
    chk_s("t6_state", state, ST_IDLE);
    #1;
    rst = 1'b0;
    step();
    chk_s("t6_state_after", state, ST_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
